// File: rtl/mem_wb_hilo_pkg.sv
// Shared constants for the MEM->WB stage and the HI/LO register pair.
// Reset and write-enable encodings are named here so every file agrees on them.
package mem_wb_hilo_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/mem_wb_hilo_hilo_reg.sv
// Architectural HI/LO register pair.
// HI and LO are always written together from one write port.
module hilo_reg
    import mem_wb_hilo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (we == WRITE_ENABLE) begin
            hi_o <= hi_i;
            lo_o <= lo_i;
        end
    end

endmodule

// File: rtl/mem_wb_hilo.sv
// MEM->WB pipeline register with the HI/LO pair and newest-first HI/LO forwarding to EX.
// The instruction already sitting in WB retires its HI/LO write even if a flush arrives.
module mem_wb_hilo
    import mem_wb_hilo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_whilo,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] ex_hi_fwd,
    output logic [DATA_W-1:0] ex_lo_fwd
);

    logic bubble;

    // A stalled MEM with a free WB must not let its held instruction retire twice.
    assign bubble = flush || (stall_mem && !stall_wb);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || bubble) begin
            wb_wd    <= '0;
            wb_wreg  <= WRITE_DISABLE;
            wb_wdata <= '0;
            wb_hi    <= '0;
            wb_lo    <= '0;
            wb_whilo <= WRITE_DISABLE;
        end else if (!stall_mem) begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
            wb_hi    <= mem_hi;
            wb_lo    <= mem_lo;
            wb_whilo <= mem_whilo;
        end
    end

    hilo_reg #(
        .DATA_W(DATA_W)
    ) u_hilo_reg (
        .clk  (clk),
        .rst  (rst),
        .we   (wb_whilo),
        .hi_i (wb_hi),
        .lo_i (wb_lo),
        .hi_o (hi_o),
        .lo_o (lo_o)
    );

    always_comb begin
        ex_hi_fwd = hi_o;
        ex_lo_fwd = lo_o;
        if (mem_whilo == WRITE_ENABLE) begin
            ex_hi_fwd = mem_hi;
            ex_lo_fwd = mem_lo;
        end else if (wb_whilo == WRITE_ENABLE) begin
            ex_hi_fwd = wb_hi;
            ex_lo_fwd = wb_lo;
        end
    end

endmodule

// File: tb/tb_mem_wb_hilo.sv
// Bench for mem_wb_hilo: a hand-derived vector table for the directed scenarios,
// then randomized traffic compared against a transaction-level model.
module tb_mem_wb_hilo;

    logic        clk = 1'b0;
    logic        rst, stall_mem, stall_wb, flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic [4:0]  wb_wd;
    logic        wb_wreg, wb_whilo;
    logic [31:0] wb_wdata, wb_hi, wb_lo, hi_o, lo_o, ex_hi_fwd, ex_lo_fwd;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_wb_hilo dut (
        .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .hi_o(hi_o), .lo_o(lo_o), .ex_hi_fwd(ex_hi_fwd), .ex_lo_fwd(ex_lo_fwd)
    );

    typedef struct {
        logic        rst, stall_mem, stall_wb, flush;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata, hi, lo;
        logic        whilo;
        logic [31:0] e_fwd_hi;
        logic [4:0]  e_wd;
        logic        e_wreg;
        logic [31:0] e_wdata;
        logic        e_whilo;
        logic [31:0] e_hi_o, e_lo_o;
    } vec_t;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata, hi, lo;
        logic        whilo;
    } instr_t;

    // Model: the instruction occupying WB plus the architectural pair
    instr_t      m_wb;
    logic [31:0] m_hi, m_lo;

    task automatic applyStimulus(input vec_t v);
        rst = v.rst; stall_mem = v.stall_mem; stall_wb = v.stall_wb; flush = v.flush;
        mem_wd = v.wd; mem_wreg = v.wreg; mem_wdata = v.wdata;
        mem_hi = v.hi; mem_lo = v.lo; mem_whilo = v.whilo;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep();
        instr_t incoming;
        incoming = '{mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo};
        if (rst) begin
            m_wb = '{5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0};
            m_hi = 0; m_lo = 0;
        end else begin
            if (m_wb.whilo) begin m_hi = m_wb.hi; m_lo = m_wb.lo; end
            if (flush || (stall_mem && !stall_wb)) m_wb = '{5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0};
            else if (!stall_mem) m_wb = incoming;
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " wb_wd"}, {27'd0, wb_wd}, {27'd0, m_wb.wd});
        checkOutput({tag, " wb_wreg"}, {31'd0, wb_wreg}, {31'd0, m_wb.wreg});
        checkOutput({tag, " wb_wdata"}, wb_wdata, m_wb.wdata);
        checkOutput({tag, " wb_hi"}, wb_hi, m_wb.hi);
        checkOutput({tag, " wb_lo"}, wb_lo, m_wb.lo);
        checkOutput({tag, " wb_whilo"}, {31'd0, wb_whilo}, {31'd0, m_wb.whilo});
        checkOutput({tag, " hi_o"}, hi_o, m_hi);
        checkOutput({tag, " lo_o"}, lo_o, m_lo);
    endtask

    task automatic checkFwdModel(input string tag);
        logic [31:0] eh, el;
        if (mem_whilo) begin eh = mem_hi; el = mem_lo; end
        else if (m_wb.whilo) begin eh = m_wb.hi; el = m_wb.lo; end
        else begin eh = m_hi; el = m_lo; end
        checkOutput({tag, " ex_hi_fwd"}, ex_hi_fwd, eh);
        checkOutput({tag, " ex_lo_fwd"}, ex_lo_fwd, el);
    endtask

    task automatic randomInputs(input logic r, input logic allow_whilo);
        rst = r;
        stall_mem = ($urandom_range(3) == 0);
        stall_wb  = stall_mem && ($urandom_range(1) == 0);
        flush     = ($urandom_range(7) == 0);
        mem_wd    = 5'($urandom);
        mem_wreg  = 1'($urandom);
        mem_wdata = $urandom;
        mem_hi    = $urandom;
        mem_lo    = $urandom;
        mem_whilo = allow_whilo && ($urandom_range(1) == 1);
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, sm, sw, fl, input logic [4:0] wd, input logic wreg,
                                input logic [31:0] wdata, hi, lo, input logic whilo, input logic [31:0] efwd,
                                input logic [4:0] ewd, input logic ewreg, input logic [31:0] ewdata,
                                input logic ewhilo, input logic [31:0] ehi, elo);
        vec_t v;
        v = '{r, sm, sw, fl, wd, wreg, wdata, hi, lo, whilo, efwd, ewd, ewreg, ewdata, ewhilo, ehi, elo};
        return v;
    endfunction

    initial begin
        // Directed table; all expectations worked out by hand from the stage rules
        //              rst sm sw fl wd    wreg wdata         hi            lo     whilo fwd_hi        e_wd  wreg e_wdata       whilo hi_o          lo_o
        vecs.push_back(mk(0, 0, 0, 0, 5'd3, 1, 32'hDEADBEEF, 0,            0,     0,    0,            5'd3, 1,   32'hDEADBEEF, 0,    0,            0));
        vecs.push_back(mk(0, 0, 0, 0, 5'd0, 0, 0,            0,            0,     0,    0,            5'd0, 0,   0,            0,    0,            0));
        vecs.push_back(mk(0, 0, 0, 0, 5'd0, 0, 0,            1,            2,     1,    1,            5'd0, 0,   0,            1,    0,            0));
        vecs.push_back(mk(0, 0, 0, 0, 5'd0, 0, 0,            0,            0,     0,    1,            5'd0, 0,   0,            0,    1,            2));
        vecs.push_back(mk(0, 0, 0, 0, 5'd0, 0, 0,            0,            0,     0,    1,            5'd0, 0,   0,            0,    1,            2));
        vecs.push_back(mk(0, 0, 0, 0, 5'd0, 0, 0,            32'hAAAA,     0,     1,    32'hAAAA,     5'd0, 0,   0,            1,    1,            2));
        vecs.push_back(mk(0, 0, 0, 0, 5'd0, 0, 0,            32'hBBBB,     5,     1,    32'hBBBB,     5'd0, 0,   0,            1,    32'hAAAA,     0));
        vecs.push_back(mk(0, 0, 0, 0, 5'd0, 0, 0,            0,            0,     0,    32'hBBBB,     5'd0, 0,   0,            0,    32'hBBBB,     5));
        vecs.push_back(mk(0, 0, 0, 0, 5'd7, 1, 32'h11111111, 0,            0,     0,    32'hBBBB,     5'd7, 1,   32'h11111111, 0,    32'hBBBB,     5));
        vecs.push_back(mk(0, 1, 0, 0, 5'd8, 1, 32'h22222222, 0,            0,     0,    32'hBBBB,     5'd0, 0,   0,            0,    32'hBBBB,     5));
        vecs.push_back(mk(0, 0, 0, 0, 5'd9, 1, 32'h33333333, 32'hC,        32'hD, 1,    32'hC,        5'd9, 1,   32'h33333333, 1,    32'hBBBB,     5));
        vecs.push_back(mk(0, 1, 1, 0, 5'd0, 0, 0,            0,            0,     0,    32'hC,        5'd9, 1,   32'h33333333, 1,    32'hC,        32'hD));
        vecs.push_back(mk(0, 1, 1, 0, 5'd0, 0, 0,            0,            0,     0,    32'hC,        5'd9, 1,   32'h33333333, 1,    32'hC,        32'hD));
        vecs.push_back(mk(0, 1, 1, 0, 5'd0, 0, 0,            0,            0,     0,    32'hC,        5'd9, 1,   32'h33333333, 1,    32'hC,        32'hD));
        vecs.push_back(mk(0, 1, 1, 1, 5'd0, 0, 0,            0,            0,     0,    32'hC,        5'd0, 0,   0,            0,    32'hC,        32'hD));
        vecs.push_back(mk(0, 0, 0, 0, 5'd0, 0, 0,            32'hE,        32'hF, 1,    32'hE,        5'd0, 0,   0,            1,    32'hC,        32'hD));
        vecs.push_back(mk(1, 0, 0, 0, 5'd0, 0, 0,            0,            0,     0,    32'hE,        5'd0, 0,   0,            0,    0,            0));
        vecs.push_back(mk(0, 0, 0, 0, 5'd0, 0, 0,            0,            0,     0,    0,            5'd0, 0,   0,            0,    0,            0));
        vecs.push_back(mk(1, 1, 1, 0, 5'd4, 1, 32'h5,        32'h9,        32'h8, 1,    32'h9,        5'd0, 0,   0,            0,    0,            0));

        // Reset for two cycles with random inputs, no MEM HI/LO write presented
        m_wb = '{5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0};
        m_hi = 0; m_lo = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            randomInputs(1'b1, 1'b0);
            @(posedge clk);
            modelStep();
            #1;
            checkModel("reset");
            checkOutput("reset ex_hi_fwd", ex_hi_fwd, 32'd0);
            checkOutput("reset ex_lo_fwd", ex_lo_fwd, 32'd0);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d ex_hi_fwd", i), ex_hi_fwd, vecs[i].e_fwd_hi);
            @(posedge clk);
            modelStep();
            #1;
            checkOutput($sformatf("vec%0d wb_wd", i), {27'd0, wb_wd}, {27'd0, vecs[i].e_wd});
            checkOutput($sformatf("vec%0d wb_wreg", i), {31'd0, wb_wreg}, {31'd0, vecs[i].e_wreg});
            checkOutput($sformatf("vec%0d wb_wdata", i), wb_wdata, vecs[i].e_wdata);
            checkOutput($sformatf("vec%0d wb_whilo", i), {31'd0, wb_whilo}, {31'd0, vecs[i].e_whilo});
            checkOutput($sformatf("vec%0d hi_o", i), hi_o, vecs[i].e_hi_o);
            checkOutput($sformatf("vec%0d lo_o", i), lo_o, vecs[i].e_lo_o);
        end

        // Randomized traffic against the model, with occasional resets
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            randomInputs($urandom_range(31) == 0, 1'b1);
            #1;
            checkFwdModel("rand");
            @(posedge clk);
            modelStep();
            #1;
            checkModel("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
